// File: rtl/ctrl_pipe_regs_pkg.sv
// Shared encodings and packed control-word bundles for the decoded-control
// pipeline (ID/EX, EX/MEM, MEM/WB).
package ctrl_pipe_regs_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int ALU_FN_W   = 6;

    localparam logic [REG_ADDR_W-1:0] LINK_REG_DEF = 4'd15;

    // Destination register select
    typedef enum logic [1:0] {
        REG_DST_RT  = 2'b00,
        REG_DST_RD  = 2'b01,
        REG_DST_15  = 2'b10,
        REG_DST_RSV = 2'b11
    } reg_dst_e;

    // ALU second-operand select; IMM is the all-zero default
    localparam logic ALU_SRC_IMM = 1'b0;
    localparam logic ALU_SRC_REG = 1'b1;

    // Write-back result select; ALU is the all-zero default
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // Branch / jump condition selects
    localparam logic SEL_BEQ   = 1'b0;
    localparam logic SEL_BNE   = 1'b1;
    localparam logic SEL_JT    = 1'b0;
    localparam logic SEL_JF    = 1'b1;
    localparam logic SEL_BRANCH = 1'b0;
    localparam logic SEL_JFLAG  = 1'b1;

    // ALU function codes referenced by tests and decode
    localparam logic [ALU_FN_W-1:0] FN_NOP = 6'h00;
    localparam logic [ALU_FN_W-1:0] FN_ADD = 6'h20;
    localparam logic [ALU_FN_W-1:0] FN_SUB = 6'h22;

    // Full word carried from ID into EX
    typedef struct packed {
        logic [ALU_FN_W-1:0]   alu_funct;
        logic                  alu_src_mux;
        logic                  is_load;
        logic                  fl_we;
        logic                  mem_we;
        logic                  sel_beq_bne;
        logic                  sel_jt_jf;
        logic                  is_branch;
        logic                  sel_jflag_branch;
        logic                  reg_we;
        logic [1:0]            wb_res_mux;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] wr_addr;
    } ctrl_word_t;

    localparam int CTRL_WORD_W = $bits(ctrl_word_t);

    // Subset still needed after EX
    typedef struct packed {
        logic                  mem_we;
        logic                  sel_beq_bne;
        logic                  sel_jt_jf;
        logic                  is_branch;
        logic                  sel_jflag_branch;
        logic                  reg_we;
        logic [1:0]            wb_res_mux;
        logic [REG_ADDR_W-1:0] wr_addr;
    } mem_word_t;

    localparam int MEM_WORD_W = $bits(mem_word_t);

    // Subset still needed in WB
    typedef struct packed {
        logic                  reg_we;
        logic [1:0]            wb_res_mux;
        logic [REG_ADDR_W-1:0] wr_addr;
    } wb_word_t;

    localparam int WB_WORD_W = $bits(wb_word_t);

    // Destination address for a given reg_dst select; the reserved encoding
    // falls back to rt (its write enable is killed separately).
    function automatic logic [REG_ADDR_W-1:0] resolve_dst(
        input logic [1:0]            reg_dst,
        input logic [REG_ADDR_W-1:0] rt,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] link
    );
        logic [REG_ADDR_W-1:0] addr;
        case (reg_dst_e'(reg_dst))
            REG_DST_RD: addr = rd;
            REG_DST_15: addr = link;
            default:    addr = rt;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/ctrl_pipe_regs_stage.sv
// One pipeline register stage: a word plus valid bit. A bubble or flush
// loads an all-zero word, which is the default encoding of every field.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_bubble,
    input  logic         flush,
    input  logic         valid_in,
    input  logic [W-1:0] d,
    output logic         valid_q,
    output logic [W-1:0] q
);

    logic [W-1:0] word_d;
    logic [W-1:0] word_q;
    logic         valid_d;

    // Next word: zeroed on bubble/flush so no x or stale enable leaks through
    always_comb begin
        word_d  = '0;
        valid_d = 1'b0;
        if (!(load_bubble || flush)) begin
            word_d  = d;
            valid_d = valid_in;
        end
    end

    // Stage register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/ctrl_pipe_regs.sv
// Carries the decoded control word from ID through EX, MEM and WB, resolves
// the destination register, inserts load-use bubbles and flushes wrong-path
// words behind a taken branch.
module ctrl_pipe_regs
    import ctrl_pipe_regs_pkg::*;
#(
    parameter int                    REG_ADDR_W = ctrl_pipe_regs_pkg::REG_ADDR_W,
    parameter int                    ALU_FN_W   = ctrl_pipe_regs_pkg::ALU_FN_W,
    parameter logic [REG_ADDR_W-1:0] LINK_REG   = LINK_REG_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [ALU_FN_W-1:0]   id_alu_funct,
    input  logic                  id_alu_src_mux,
    input  logic                  id_is_load,
    input  logic                  id_fl_write_enable,
    input  logic                  id_mem_write_enable,
    input  logic                  id_sel_beq_bne,
    input  logic                  id_sel_jt_jf,
    input  logic                  id_is_branch,
    input  logic                  id_sel_jflag_branch,
    input  logic                  id_reg_write_enable,
    input  logic [1:0]            id_reg_dst_mux,
    input  logic [1:0]            id_wb_res_mux,

    input  logic                  mem_branch_taken,

    output logic                  stall_pipeline,

    output logic [ALU_FN_W-1:0]   ex_alu_funct,
    output logic                  ex_alu_src_mux,
    output logic                  ex_is_load,
    output logic                  ex_fl_write_enable,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,

    output logic                  mem_mem_write_enable,
    output logic                  mem_sel_beq_bne,
    output logic                  mem_sel_jt_jf,
    output logic                  mem_is_branch,
    output logic                  mem_sel_jflag_branch,
    output logic                  mem_reg_write_enable,
    output logic [REG_ADDR_W-1:0] mem_wr_addr,

    output logic [1:0]            wb_res_mux,
    output logic                  wb_reg_write_enable,
    output logic [REG_ADDR_W-1:0] wb_wr_addr
);

    ctrl_word_t id_word;
    ctrl_word_t ex_word;
    mem_word_t  ex_mem_next;
    mem_word_t  mem_word;
    wb_word_t   mem_wb_next;
    wb_word_t   wb_word;

    logic ex_valid;
    logic mem_valid;
    logic wb_valid;
    logic id_bubble;

    // Assemble the ID word and resolve the destination register
    always_comb begin
        id_word                  = '0;
        id_word.alu_funct        = id_alu_funct;
        id_word.alu_src_mux      = id_alu_src_mux;
        id_word.is_load          = id_is_load;
        id_word.fl_we            = id_fl_write_enable;
        id_word.mem_we           = id_mem_write_enable;
        id_word.sel_beq_bne      = id_sel_beq_bne;
        id_word.sel_jt_jf        = id_sel_jt_jf;
        id_word.is_branch        = id_is_branch;
        id_word.sel_jflag_branch = id_sel_jflag_branch;
        id_word.wb_res_mux       = id_wb_res_mux;
        id_word.rs               = id_rs;
        id_word.rt               = id_rt;
        id_word.wr_addr          = resolve_dst(id_reg_dst_mux, id_rt, id_rd, LINK_REG);
        // The reserved reg_dst encoding never writes the register file
        id_word.reg_we           = id_reg_write_enable &&
                                   (reg_dst_e'(id_reg_dst_mux) != REG_DST_RSV);
    end

    // Load-use hazard: a load in EX whose target feeds the ID instruction.
    // A taken branch in MEM kills both, so no stall is needed then.
    assign stall_pipeline = ex_valid & ex_word.is_load & ex_word.reg_we & id_valid &
                            ((ex_word.rt == id_rs) | (ex_word.rt == id_rt)) &
                            ~mem_branch_taken;

    assign id_bubble = stall_pipeline | ~id_valid;

    ctrl_stage_reg #(.W(CTRL_WORD_W)) u_id_ex (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (id_bubble),
        .flush       (mem_branch_taken),
        .valid_in    (id_valid),
        .d           (id_word),
        .valid_q     (ex_valid),
        .q           (ex_word)
    );

    // Fields that continue past EX
    always_comb begin
        ex_mem_next                  = '0;
        ex_mem_next.mem_we           = ex_word.mem_we;
        ex_mem_next.sel_beq_bne      = ex_word.sel_beq_bne;
        ex_mem_next.sel_jt_jf        = ex_word.sel_jt_jf;
        ex_mem_next.is_branch        = ex_word.is_branch;
        ex_mem_next.sel_jflag_branch = ex_word.sel_jflag_branch;
        ex_mem_next.reg_we           = ex_word.reg_we;
        ex_mem_next.wb_res_mux       = ex_word.wb_res_mux;
        ex_mem_next.wr_addr          = ex_word.wr_addr;
    end

    ctrl_stage_reg #(.W(MEM_WORD_W)) u_ex_mem (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (~ex_valid),
        .flush       (mem_branch_taken),
        .valid_in    (ex_valid),
        .d           (ex_mem_next),
        .valid_q     (mem_valid),
        .q           (mem_word)
    );

    // Fields that continue past MEM; the branch word itself still retires
    always_comb begin
        mem_wb_next            = '0;
        mem_wb_next.reg_we     = mem_word.reg_we;
        mem_wb_next.wb_res_mux = mem_word.wb_res_mux;
        mem_wb_next.wr_addr    = mem_word.wr_addr;
    end

    ctrl_stage_reg #(.W(WB_WORD_W)) u_mem_wb (
        .clk         (clk),
        .rst         (rst),
        .load_bubble (~mem_valid),
        .flush       (1'b0),
        .valid_in    (mem_valid),
        .d           (mem_wb_next),
        .valid_q     (wb_valid),
        .q           (wb_word)
    );

    assign ex_alu_funct       = ex_word.alu_funct;
    assign ex_alu_src_mux     = ex_word.alu_src_mux;
    assign ex_is_load         = ex_word.is_load;
    assign ex_fl_write_enable = ex_word.fl_we;
    assign ex_rs              = ex_word.rs;
    assign ex_rt              = ex_word.rt;

    assign mem_mem_write_enable = mem_word.mem_we;
    assign mem_sel_beq_bne      = mem_word.sel_beq_bne;
    assign mem_sel_jt_jf        = mem_word.sel_jt_jf;
    assign mem_is_branch        = mem_word.is_branch;
    assign mem_sel_jflag_branch = mem_word.sel_jflag_branch;
    assign mem_reg_write_enable = mem_word.reg_we;
    assign mem_wr_addr          = mem_word.wr_addr;

    assign wb_res_mux          = wb_word.wb_res_mux;
    assign wb_reg_write_enable = wb_word.reg_we & wb_valid;
    assign wb_wr_addr          = wb_word.wr_addr;

endmodule
